// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the executestage datapath: owns the PC,
// latches instructions from a synchronous instruction memory and resolves jumps/halt.
module control_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [5:0]  RESET_PC    = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic [15:0] imem_data,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic [5:0]  imem_addr,
  output logic        imem_rd_en,
  output logic [4:0]  opcode,
  output logic        am,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [2:0]  s_r_amount,
  output logic [3:0]  mem_addr,
  output logic [5:0]  instr_mem_addr,
  output logic        exe_enable,
  output logic [5:0]  pc,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned PC_W  = 6;
  localparam int unsigned IR_W  = 16;
  localparam int unsigned CNT_W = 3;

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JZ   = 5'b11001;
  localparam logic [4:0] OP_JC   = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [IR_W-1:0]  ir_q, ir_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             z_q, z_nxt;
  logic             c_q, c_nxt;
  logic             refetch_q, refetch_nxt;

  // State and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cnt_q     <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      refetch_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      ir_q      <= ir_nxt;
      cnt_q     <= cnt_nxt;
      z_q       <= z_nxt;
      c_q       <= c_nxt;
      refetch_q <= refetch_nxt;
    end
  end

  // Next-state and Moore control outputs; stall gates the strobes and freezes everything
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    ir_nxt      = ir_q;
    cnt_nxt     = cnt_q;
    z_nxt       = z_q;
    c_nxt       = c_q;
    refetch_nxt = refetch_q;
    exe_enable  = 1'b0;
    imem_rd_en  = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        imem_rd_en = !stall;
        if (!stall) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        // A stall here may let the memory word go stale, so the read is reissued
        if (stall) begin
          refetch_nxt = 1'b1;
        end else if (refetch_q) begin
          refetch_nxt = 1'b0;
          state_nxt   = S_FETCH;
        end else begin
          ir_nxt  = imem_data;
          pc_nxt  = pc_q + PC_W'(1);
          cnt_nxt = '0;
          unique case (imem_data[15:11])
            OP_HALT:               state_nxt = S_HALT;
            OP_JMP, OP_JZ, OP_JC:  state_nxt = S_BRANCH;
            default:               state_nxt = S_EXECUTE;
          endcase
        end
      end
      S_EXECUTE: begin
        busy       = 1'b1;
        exe_enable = !stall;
        if (!stall) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        busy = 1'b1;
        if (!stall) begin
          z_nxt     = zero_flag;
          c_nxt     = carry_flag;
          state_nxt = S_FETCH;
        end
      end
      S_BRANCH: begin
        busy = 1'b1;
        if (!stall) begin
          state_nxt = S_FETCH;
          unique case (ir_q[15:11])
            OP_JMP:  pc_nxt = ir_q[5:0];
            OP_JZ:   if (z_q) pc_nxt = ir_q[5:0];
            OP_JC:   if (c_q) pc_nxt = ir_q[5:0];
            default: pc_nxt = pc_q;
          endcase
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign opcode         = ir_q[15:11];
  assign am             = ir_q[10];
  assign rd             = ir_q[9:7];
  assign rs1            = ir_q[6:4];
  assign rs2            = ir_q[3:1];
  assign s_r_amount     = ir_q[6:4];
  assign mem_addr       = ir_q[3:0];
  assign instr_mem_addr = ir_q[5:0];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed programs with literal expectations plus
// randomized programs/stalls/flags checked every cycle against a schedule-queue model.
module tb_control_sequencer;

  localparam int unsigned EXEC_CYCLES = 3;
  localparam int K_IDLE = 0, K_FETCH = 1, K_DEC = 2, K_EXE = 3, K_WB = 4, K_BR = 5, K_HALT = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] imem_data = '0;
  logic        zero_flag, carry_flag;
  logic        dir_mode = 1'b1;
  logic        rnd_zero = 1'b0, rnd_carry = 1'b0;

  logic [5:0]  imem_addr;
  logic        imem_rd_en;
  logic [4:0]  opcode;
  logic        am;
  logic [2:0]  rd, rs1, rs2, s_r_amount;
  logic [3:0]  mem_addr;
  logic [5:0]  instr_mem_addr;
  logic        exe_enable;
  logic [5:0]  pc;
  logic        busy, halted;

  logic [15:0] mem [64];
  int n_checks = 0;
  int n_pass   = 0;

  control_sequencer #(.EXEC_CYCLES(EXEC_CYCLES), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .imem_data(imem_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .imem_addr(imem_addr),
    .imem_rd_en(imem_rd_en), .opcode(opcode), .am(am), .rd(rd), .rs1(rs1), .rs2(rs2),
    .s_r_amount(s_r_amount), .mem_addr(mem_addr), .instr_mem_addr(instr_mem_addr),
    .exe_enable(exe_enable), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Directed programs raise the flags at fixed PCs so the branch outcomes are known
  assign zero_flag  = dir_mode ? (pc == 6'd41) : rnd_zero;
  assign carry_flag = dir_mode ? (pc == 6'd11) : rnd_carry;

  // Synchronous instruction memory that holds its output while not read
  always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: architectural state plus a queue of the cycle kinds still to come
  int          sched[$];
  logic [5:0]  m_pc;
  logic [15:0] m_ir;
  logic        m_z, m_c, m_halted, m_refetch;
  int          m_kind;
  logic [4:0]  m_op;

  task automatic push_fd();
    sched.push_back(K_FETCH);
    sched.push_back(K_DEC);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sched.delete();
      m_pc = 6'd0; m_ir = '0; m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0; m_refetch = 1'b0;
      m_kind = K_IDLE;
    end else begin
      m_kind = (sched.size() > 0) ? sched[0] : (m_halted ? K_HALT : K_IDLE);
    end

    check("ctrl", {imem_rd_en, exe_enable, busy, halted},
          {m_kind == K_FETCH && !stall, m_kind == K_EXE && !stall,
           m_kind >= K_FETCH && m_kind <= K_BR, m_kind == K_HALT});
    check("pc", {pc, imem_addr}, {m_pc, m_pc});
    check("fields", {opcode, am, rd, rs1, rs2, s_r_amount, mem_addr, instr_mem_addr},
          {m_ir[15:11], m_ir[10], m_ir[9:7], m_ir[6:4], m_ir[3:1], m_ir[6:4], m_ir[3:0], m_ir[5:0]});

    if (!reset) begin
      if (m_kind == K_IDLE) begin
        if (start) push_fd();
      end else if (m_kind != K_HALT) begin
        if (stall) begin
          if (m_kind == K_DEC) m_refetch = 1'b1;
        end else begin
          void'(sched.pop_front());
          case (m_kind)
            K_DEC: begin
              if (m_refetch) begin
                m_refetch = 1'b0;
                push_fd();
              end else begin
                m_ir = mem[m_pc];
                m_pc = m_pc + 6'd1;
                m_op = m_ir[15:11];
                if (m_op == 5'd31) m_halted = 1'b1;
                else if (m_op >= 5'd24 && m_op <= 5'd26) sched.push_back(K_BR);
                else begin
                  for (int i = 0; i < int'(EXEC_CYCLES); i++) sched.push_back(K_EXE);
                  sched.push_back(K_WB);
                end
              end
            end
            K_WB: begin
              m_z = zero_flag;
              m_c = carry_flag;
              push_fd();
            end
            K_BR: begin
              m_op = m_ir[15:11];
              if (m_op == 5'd24 || (m_op == 5'd25 && m_z) || (m_op == 5'd26 && m_c))
                m_pc = m_ir[5:0];
              push_fd();
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-cycle logs of a directed run, cycle 0 being the FETCH after start
  logic       lg_exe  [64];
  logic       lg_rd   [64];
  logic       lg_busy [64];
  logic       lg_halt [64];
  logic [5:0] lg_pc   [64];
  logic [5:0] lg_addr [64];
  logic [4:0] lg_op   [64];
  logic [2:0] lg_rdf  [64];

  task automatic run_cycles(input int n, input int st_lo, input int st_hi);
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1 start = 1'b0; stall = (c >= st_lo && c <= st_hi);
      @(negedge clk);
      lg_exe[c] = exe_enable; lg_rd[c] = imem_rd_en; lg_busy[c] = busy; lg_halt[c] = halted;
      lg_pc[c] = pc; lg_addr[c] = imem_addr; lg_op[c] = opcode; lg_rdf[c] = rd;
    end
    @(posedge clk); #1 stall = 1'b0;
  endtask

  function automatic logic [15:0] exe_bits(input int n);
    logic [15:0] v = '0;
    for (int c = 0; c < n; c++) v[c] = lg_exe[c];
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; stall = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      int r;
      logic [4:0] op;
      r = int'($urandom_range(15, 0));
      if (r < 9)       op = 5'($urandom_range(23, 0));
      else if (r < 14) op = 5'(24 + $urandom_range(2, 0));
      else if (r == 14) op = 5'd31;
      else             op = 5'($urandom_range(30, 27));
      mem[i] = {op, 11'($urandom)};
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int i = 0; i < 64; i++) mem[i] = 16'hF800;
    mem[0]  = 16'h1BD0; mem[1]  = 16'hC028;
    mem[40] = 16'h0812; mem[41] = 16'hC80A;
    mem[10] = 16'h0812; mem[11] = 16'hC814; mem[12] = 16'hD01E;
    mem[30] = 16'h0812; mem[31] = 16'hD005; mem[32] = 16'hF800;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {pc, busy, halted, exe_enable, imem_rd_en, opcode}, 64'd0);
    reset = 1'b0;

    // Walk through ALU, JMP, JZ taken/not, JC taken/not, HALT
    run_cycles(42, -1, -1);
    check("first_fetch", {lg_rd[0], lg_addr[0]}, {1'b1, 6'd0});
    check("alu_jmp_exe_window", exe_bits(10), 16'b0000_0000_0001_1100);
    check("alu_pc", lg_pc[2], 6'd1);
    check("alu_opcode", lg_op[2], 5'b00011);
    check("alu_rd", lg_rdf[2], 3'b111);
    check("alu_len", {lg_rd[6], lg_addr[6]}, {1'b1, 6'd1});
    check("jmp_target", {lg_rd[9], lg_addr[9]}, {1'b1, 6'd40});
    check("jz_taken", lg_pc[18], 6'd10);
    check("jz_not_taken", lg_pc[27], 6'd12);
    check("jc_taken", lg_pc[30], 6'd30);
    check("jc_not_taken", lg_pc[39], 6'd32);
    check("halt_outputs", {lg_busy[41], lg_halt[41], lg_exe[41]}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("halt_ignores_start", {pc, halted, busy}, {6'd33, 1'b1, 1'b0});

    // Four stall cycles in the middle of EXECUTE
    mem[1] = 16'hF800;
    do_reset();
    run_cycles(13, 3, 6);
    check("stall_exe_window", exe_bits(13), 16'b0000_0001_1000_0100);
    check("stall_busy_held", lg_busy[4], 1'b1);
    check("stall_next_fetch", {lg_rd[10], lg_addr[10]}, {1'b1, 6'd1});
    check("stall_halt", lg_halt[12], 1'b1);

    // Asynchronous reset while executing
    do_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = exe_enable;
    end
    check("exe_reached", found, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset", {pc, imem_addr, busy, halted, exe_enable, imem_rd_en, opcode, rd},
             64'd0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    // PC wraps from 63 to 0
    mem[0] = 16'hC03F; mem[63] = 16'h1BD0;
    do_reset();
    run_cycles(6, -1, -1);
    check("fetch_63", {lg_rd[3], lg_addr[3]}, {1'b1, 6'd63});
    check("pc_wrap", lg_pc[5], 6'd0);

    // Random programs, stalls, flags and start pulses
    dir_mode = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1 reset = 1'b1; start = 1'b0; stall = 1'b0;
      fill_random();
      @(posedge clk); #1 reset = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk); #1;
        start     = ($urandom_range(9, 0) == 0);
        stall     = ($urandom_range(5, 0) == 0);
        rnd_zero  = 1'($urandom);
        rnd_carry = 1'($urandom);
      end
    end

    @(posedge clk); #1 start = 1'b0; stall = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
